counter_ctrl_port: RTL and testbench

Per-counter bus-interface and count-register stage of the 8254 timer, placed directly upstream of each mode engine (Mode1 and siblings). It decodes CPU control-word and count writes, assembles the 16-bit initial count, and presents it to the mode engine as `msb`/`lsb` together with the selected mode. It also serves CPU reads of the live or latched count. One instance is used per counter, selected by `COUNTER_ID`.

---
 rtl/counter_ctrl_port.sv | 152 +++++++++++++++
 tb/tb_counter_ctrl_port.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl_port.sv
// rtl/counter_ctrl_port.sv - 8254 per-counter bus decode, count assembly and read-back stage
module counter_ctrl_port #(
  parameter int COUNTER_ID = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic [1:0]  a,
  input  logic [7:0]  din,
  input  logic [15:0] count_now,
  output logic [7:0]  dout,
  output logic        dout_oe,
  output logic [7:0]  msb,
  output logic [7:0]  lsb,
  output logic [2:0]  mode,
  output logic        bcd,
  output logic        count_wr,
  output logic        cw_wr
);

  localparam logic [1:0] ID = 2'(COUNTER_ID);

  logic        cap_cs_n;
  logic [1:0]  cap_a;
  logic [7:0]  cap_din;
  logic        wr_n_q;
  logic        rd_sel_q;
  logic [1:0]  rw;
  logic        wtog;
  logic        rtog;
  logic        latched;
  logic [7:0]  lsb_stage;
  logic [15:0] latch_reg;

  logic        commit;
  logic        cw_hit;
  logic        cnt_hit;
  logic        rd_sel;
  logic        rd_done;
  logic        rd_hi;
  logic        last_byte;
  logic [15:0] rd_src;

  // A write commits on the first high sample of wr_n, using what was captured while it was low
  assign commit    = wr_n & ~wr_n_q & ~cap_cs_n;
  assign cw_hit    = commit & (cap_a == 2'b11) & (cap_din[7:6] == ID);
  assign cnt_hit   = commit & (cap_a == ID);

  // A read overlapping a write is ignored entirely
  assign rd_sel    = ~cs_n & ~rd_n & wr_n & (a == ID);
  assign rd_done   = rd_sel_q & rd_n;
  assign rd_hi     = (rw == 2'b10) | ((rw == 2'b11) & rtog);
  assign last_byte = (rw != 2'b11) | rtog;
  assign rd_src    = latched ? latch_reg : count_now;

  always_comb begin
    dout    = 8'h00;
    dout_oe = 1'b0;
    if (rd_sel) begin
      dout_oe = 1'b1;
      dout    = rd_hi ? rd_src[15:8] : rd_src[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_cs_n  <= 1'b1;
      cap_a     <= 2'b00;
      cap_din   <= 8'h00;
      wr_n_q    <= 1'b1;
      rd_sel_q  <= 1'b0;
      rw        <= 2'b00;
      mode      <= 3'd0;
      bcd       <= 1'b0;
      msb       <= 8'h00;
      lsb       <= 8'h00;
      lsb_stage <= 8'h00;
      wtog      <= 1'b0;
      rtog      <= 1'b0;
      latched   <= 1'b0;
      latch_reg <= 16'h0000;
      count_wr  <= 1'b0;
      cw_wr     <= 1'b0;
    end else begin
      wr_n_q   <= wr_n;
      rd_sel_q <= rd_sel;
      count_wr <= 1'b0;
      cw_wr    <= 1'b0;

      if (!wr_n) begin
        cap_cs_n <= cs_n;
        cap_a    <= a;
        cap_din  <= din;
      end

      if (rd_done) begin
        if (rw == 2'b11) rtog <= ~rtog;
        if (last_byte) latched <= 1'b0;
      end

      // Control-word effects are placed after read completion so they take priority
      if (cw_hit) begin
        if (cap_din[5:4] == 2'b00) begin
          if (!latched) begin
            latch_reg <= count_now;
            latched   <= 1'b1;
          end
        end else begin
          rw      <= cap_din[5:4];
          mode    <= cap_din[3] & cap_din[2] ? {1'b0, cap_din[2:1]} : cap_din[3:1];
          bcd     <= cap_din[0];
          msb     <= 8'h00;
          lsb     <= 8'h00;
          wtog    <= 1'b0;
          rtog    <= 1'b0;
          latched <= 1'b0;
          cw_wr   <= 1'b1;
        end
      end

      if (cnt_hit) begin
        case (rw)
          2'b01: begin
            lsb      <= cap_din;
            msb      <= 8'h00;
            count_wr <= 1'b1;
          end
          2'b10: begin
            msb      <= cap_din;
            lsb      <= 8'h00;
            count_wr <= 1'b1;
          end
          2'b11: begin
            if (!wtog) begin
              lsb_stage <= cap_din;
              wtog      <= 1'b1;
            end else begin
              msb      <= cap_din;
              lsb      <= lsb_stage;
              wtog     <= 1'b0;
              count_wr <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl_port.sv
// tb/tb_counter_ctrl_port.sv - scoreboard bench for counter_ctrl_port (COUNTER_ID 0)
module tb_counter_ctrl_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        rd_n = 1'b1;
  logic [1:0]  a = 2'b00;
  logic [7:0]  din = 8'h00;
  logic [15:0] count_now = 16'h0000;
  logic [7:0]  dout;
  logic        dout_oe;
  logic [7:0]  msb;
  logic [7:0]  lsb;
  logic [2:0]  mode;
  logic        bcd;
  logic        count_wr;
  logic        cw_wr;

  int tests = 0;
  int fails = 0;
  int cnp = 0;
  int cwp = 0;
  logic [31:0] sb[$];

  counter_ctrl_port #(.COUNTER_ID(0)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .a(a), .din(din), .count_now(count_now), .dout(dout), .dout_oe(dout_oe),
    .msb(msb), .lsb(lsb), .mode(mode), .bcd(bcd),
    .count_wr(count_wr), .cw_wr(cw_wr)
  );

  always #5 clk = ~clk;

  // Strobe pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (count_wr) cnp <= cnp + 1;
    if (cw_wr)    cwp <= cwp + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = (sb.size() != 0) ? sb.pop_front() : ~obs;
    check(tag, obs, exp);
  endtask

  function automatic logic [31:0] pack(input int cw, input int cn, input logic b,
                                       input logic [2:0] m, input logic [15:0] v);
    return {4'(cw), 4'(cn), 4'b0, b, m, v};
  endfunction

  function automatic logic [31:0] observe(input int w0, input int c0);
    return pack(cwp - w0, cnp - c0, bcd, mode, {msb, lsb});
  endfunction

  task automatic do_write(input string tag, input logic [1:0] addr, input logic [7:0] data,
                          input logic csn, input logic [31:0] exp);
    int w0;
    int c0;
    w0 = cwp;
    c0 = cnp;
    sb.push_back(exp);
    @(negedge clk);
    cs_n = csn; a = addr; din = data; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1; cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    sb_check(tag, observe(w0, c0));
  endtask

  task automatic do_read(input string tag, input logic [1:0] addr, input logic oe,
                         input logic [7:0] exp);
    logic [31:0] obs;
    sb.push_back({23'b0, oe, exp});
    @(negedge clk);
    cs_n = 1'b0; a = addr; rd_n = 1'b0;
    #1;
    obs = {23'b0, dout_oe, dout};
    @(negedge clk);
    rd_n = 1'b1; cs_n = 1'b1;
    @(negedge clk);
    sb_check(tag, obs);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    sb.push_back(pack(0, 0, 1'b0, 3'd0, 16'h0000));
    sb_check("reset_state", observe(cwp, cnp));
    sb.push_back(32'h0);
    sb_check("reset_dout", {23'b0, dout_oe, dout});
    @(negedge clk);
    rst_n = 1'b1;

    do_write("cw_32", 2'b11, 8'h32, 1'b0, pack(1, 0, 1'b0, 3'd1, 16'h0000));
    do_write("rw11_lo", 2'b00, 8'h34, 1'b0, pack(0, 0, 1'b0, 3'd1, 16'h0000));
    do_write("rw11_hi", 2'b00, 8'h12, 1'b0, pack(0, 1, 1'b0, 3'd1, 16'h1234));

    do_write("cw_14", 2'b11, 8'h14, 1'b0, pack(1, 0, 1'b0, 3'd2, 16'h0000));
    do_write("rw01_wr", 2'b00, 8'hAB, 1'b0, pack(0, 1, 1'b0, 3'd2, 16'h00AB));
    do_write("cw_1e_mode7", 2'b11, 8'h1E, 1'b0, pack(1, 0, 1'b0, 3'd3, 16'h0000));

    count_now = 16'hBEEF;
    do_read("rw01_rd", 2'b00, 1'b1, 8'hEF);
    do_read("rd_other_addr", 2'b01, 1'b0, 8'h00);

    do_write("cw_30", 2'b11, 8'h30, 1'b0, pack(1, 0, 1'b0, 3'd0, 16'h0000));
    count_now = 16'h5678;
    do_write("latch_1", 2'b11, 8'h00, 1'b0, pack(0, 0, 1'b0, 3'd0, 16'h0000));
    count_now = 16'h1111;
    do_write("latch_2", 2'b11, 8'h00, 1'b0, pack(0, 0, 1'b0, 3'd0, 16'h0000));
    do_read("latch_rd_lo", 2'b00, 1'b1, 8'h78);
    do_read("latch_rd_hi", 2'b00, 1'b1, 8'h56);
    do_read("live_rd_lo", 2'b00, 1'b1, 8'h11);
    do_read("live_rd_hi", 2'b00, 1'b1, 8'h11);

    // Write and read strobes together: write wins, read is suppressed
    sb.push_back(32'h0);
    @(negedge clk);
    cs_n = 1'b0; a = 2'b00; din = 8'h22; wr_n = 1'b0; rd_n = 1'b0;
    #1;
    sb_check("wr_rd_overlap_oe", {31'b0, dout_oe});
    @(negedge clk);
    wr_n = 1'b1; rd_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(negedge clk);
    do_write("overlap_pair_hi", 2'b00, 8'h33, 1'b0, pack(0, 1, 1'b0, 3'd0, 16'h3322));
    count_now = 16'hA5C3;
    do_read("rtog_kept_lo", 2'b00, 1'b1, 8'hC3);
    do_read("rtog_kept_hi", 2'b00, 1'b1, 8'hA5);

    do_write("cw_other_sc", 2'b11, 8'h72, 1'b0, pack(0, 0, 1'b0, 3'd0, 16'h3322));
    do_write("wr_other_addr", 2'b01, 8'h55, 1'b0, pack(0, 0, 1'b0, 3'd0, 16'h3322));
    do_write("wr_no_cs", 2'b00, 8'h66, 1'b1, pack(0, 0, 1'b0, 3'd0, 16'h3322));
    do_write("cw_31_bcd", 2'b11, 8'h31, 1'b0, pack(1, 0, 1'b1, 3'd0, 16'h0000));
    do_write("half_pair", 2'b00, 8'h99, 1'b0, pack(0, 0, 1'b1, 3'd0, 16'h0000));

    sb.push_back(pack(0, 0, 1'b0, 3'd0, 16'h0000));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb_check("mid_reset", observe(cwp, cnp));
    @(negedge clk);
    rst_n = 1'b1;
    do_write("post_reset_wr", 2'b00, 8'h77, 1'b0, pack(0, 0, 1'b0, 3'd0, 16'h0000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
